// File: rtl/rng_pkg.sv
// Shared definitions for the xorshift32 stream checker: state encoding,
// counter widths and the xorshift32 step function.
package rng_pkg;

    localparam int ERR_CNT_W  = 16;
    localparam int BEAT_CNT_W = 32;
    localparam int MISS_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_LOST  = 2'd2
    } rng_chk_state_t;

    // One xorshift32 step; every shift is truncated to 32 bits.
    function automatic logic [31:0] xorshift32_next(input logic [31:0] x);
        logic [31:0] t;
        t = x ^ (x << 13);
        t = t ^ (t >> 17);
        return t ^ (t << 5);
    endfunction

endpackage

// File: rtl/rng_expect.sv
// Expected-state register for the checker: holds the 32-bit xorshift32
// state, reloads SEED on request and steps once per accepted beat.
module rng_expect
    import rng_pkg::*;
#(
    parameter logic [31:0] SEED = 32'd1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic       i_advance,
    output logic [7:0] o_exp_byte
);

    logic [31:0] r_exp;

    // Load has priority over advance so a start always realigns the stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exp <= SEED;
        end else if (i_load) begin
            r_exp <= SEED;
        end else if (i_advance) begin
            r_exp <= xorshift32_next(r_exp);
        end
    end

    assign o_exp_byte = r_exp[7:0];

endmodule

// File: rtl/rng_checker.sv
// Checker for a byte stream produced by an xorshift32 generator.
// Compares each accepted byte against the locally predicted state, counts
// beats and mismatches, and declares loss of sync after MAX_MISS
// consecutive misses.
// Optional build macro RNG_CHECKER_FIRST_ERR_EN adds capture of the first
// mismatch (beat index, expected byte, observed byte) since start/reset.
module rng_checker
    import rng_pkg::*;
#(
    parameter logic [31:0] SEED     = 32'd1,
    parameter int          MAX_MISS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  locked,
    output logic                  lost,
    output logic                  err_pulse,
    output logic [ERR_CNT_W-1:0]  err_cnt,
    output logic [BEAT_CNT_W-1:0] beat_cnt
`ifdef RNG_CHECKER_FIRST_ERR_EN
    ,
    output logic                  first_err_valid,
    output logic [BEAT_CNT_W-1:0] first_err_idx,
    output logic [7:0]            first_err_exp,
    output logic [7:0]            first_err_got
`endif
);

    localparam logic [MISS_W-1:0]     MAX_MISS_L = MISS_W'(MAX_MISS);
    localparam logic [MISS_W-1:0]     MISS_ONE   = MISS_W'(1);
    localparam logic [ERR_CNT_W-1:0]  ERR_ONE    = ERR_CNT_W'(1);
    localparam logic [BEAT_CNT_W-1:0] BEAT_ONE   = BEAT_CNT_W'(1);

    rng_chk_state_t        r_state;
    rng_chk_state_t        w_state_next;
    logic [MISS_W-1:0]     r_miss_run;
    logic [MISS_W-1:0]     w_miss_next;
    logic [MISS_W-1:0]     w_miss_inc;
    logic [ERR_CNT_W-1:0]  r_err_cnt;
    logic [ERR_CNT_W-1:0]  w_err_cnt_next;
    logic [BEAT_CNT_W-1:0] r_beat_cnt;
    logic [BEAT_CNT_W-1:0] w_beat_cnt_next;
    logic                  r_err_pulse;
    logic                  w_err_pulse_next;
    logic                  r_locked;
    logic                  r_lost;
    logic [7:0]            w_exp_byte;
    logic                  w_beat;
    logic                  w_mismatch;

    // A beat only counts in CHECK; a coincident start discards it.
    assign w_beat     = in_valid && (r_state == ST_CHECK) && !start;
    assign w_mismatch = w_beat && (in_data != w_exp_byte);
    assign w_miss_inc = r_miss_run + MISS_ONE;

    rng_expect #(
        .SEED(SEED)
    ) u_expect (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (start),
        .i_advance (w_beat),
        .o_exp_byte(w_exp_byte)
    );

    // Next-state and counter update rules for the checker FSM.
    always_comb begin
        w_state_next     = r_state;
        w_miss_next      = r_miss_run;
        w_err_cnt_next   = r_err_cnt;
        w_beat_cnt_next  = r_beat_cnt;
        w_err_pulse_next = 1'b0;
        if (start) begin
            w_state_next    = ST_CHECK;
            w_miss_next     = '0;
            w_err_cnt_next  = '0;
            w_beat_cnt_next = '0;
        end else if (w_beat) begin
            w_beat_cnt_next = r_beat_cnt + BEAT_ONE;
            if (w_mismatch) begin
                w_err_pulse_next = 1'b1;
                w_miss_next      = w_miss_inc;
                if (r_err_cnt != '1) begin
                    w_err_cnt_next = r_err_cnt + ERR_ONE;
                end
                if (w_miss_inc == MAX_MISS_L) begin
                    w_state_next = ST_LOST;
                end
            end else begin
                w_miss_next = '0;
            end
        end
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_miss_run  <= '0;
            r_err_cnt   <= '0;
            r_beat_cnt  <= '0;
            r_err_pulse <= 1'b0;
            r_locked    <= 1'b0;
            r_lost      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_miss_run  <= w_miss_next;
            r_err_cnt   <= w_err_cnt_next;
            r_beat_cnt  <= w_beat_cnt_next;
            r_err_pulse <= w_err_pulse_next;
            r_locked    <= (w_state_next == ST_CHECK);
            r_lost      <= (w_state_next == ST_LOST);
        end
    end

    assign in_ready  = 1'b1;
    assign locked    = r_locked;
    assign lost      = r_lost;
    assign err_pulse = r_err_pulse;
    assign err_cnt   = r_err_cnt;
    assign beat_cnt  = r_beat_cnt;

`ifdef RNG_CHECKER_FIRST_ERR_EN
    logic                  r_fe_valid;
    logic [BEAT_CNT_W-1:0] r_fe_idx;
    logic [7:0]            r_fe_exp;
    logic [7:0]            r_fe_got;

    // Latch the first mismatch; the index is the beat count including it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fe_valid <= 1'b0;
            r_fe_idx   <= '0;
            r_fe_exp   <= '0;
            r_fe_got   <= '0;
        end else if (start) begin
            r_fe_valid <= 1'b0;
            r_fe_idx   <= '0;
            r_fe_exp   <= '0;
            r_fe_got   <= '0;
        end else if (w_mismatch && !r_fe_valid) begin
            r_fe_valid <= 1'b1;
            r_fe_idx   <= w_beat_cnt_next;
            r_fe_exp   <= w_exp_byte;
            r_fe_got   <= in_data;
        end
    end

    assign first_err_valid = r_fe_valid;
    assign first_err_idx   = r_fe_idx;
    assign first_err_exp   = r_fe_exp;
    assign first_err_got   = r_fe_got;
`endif

endmodule

// File: tb/tb_rng_checker.sv
// Self-checking bench for rng_checker: directed scenarios plus a random
// stream, compared every cycle against a behavioural reference model.
module tb_rng_checker;

    localparam logic [31:0] SEED     = 32'd1;
    localparam int          MAX_MISS = 4;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        locked;
    logic        lost;
    logic        err_pulse;
    logic [15:0] err_cnt;
    logic [31:0] beat_cnt;
`ifdef RNG_CHECKER_FIRST_ERR_EN
    logic        first_err_valid;
    logic [31:0] first_err_idx;
    logic [7:0]  first_err_exp;
    logic [7:0]  first_err_got;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 idle, 1 checking, 2 lost.
    int          m_mode;
    logic [31:0] m_x;
    int unsigned m_beats;
    int          m_errs;
    int          m_run;
    bit          m_pulse;
    bit          m_fe_valid;
    int unsigned m_fe_idx;
    logic [7:0]  m_fe_exp;
    logic [7:0]  m_fe_got;

    rng_checker #(
        .SEED    (SEED),
        .MAX_MISS(MAX_MISS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .locked   (locked),
        .lost     (lost),
        .err_pulse(err_pulse),
        .err_cnt  (err_cnt),
        .beat_cnt (beat_cnt)
`ifdef RNG_CHECKER_FIRST_ERR_EN
        ,
        .first_err_valid(first_err_valid),
        .first_err_idx  (first_err_idx),
        .first_err_exp  (first_err_exp),
        .first_err_got  (first_err_got)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_next(input logic [31:0] x);
        logic [31:0] t;
        t = x ^ (x << 13);
        t = t ^ (t >> 17);
        return t ^ (t << 5);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_x = SEED; m_beats = 0; m_errs = 0; m_run = 0; m_pulse = 0;
        m_fe_valid = 0; m_fe_idx = 0; m_fe_exp = 8'h00; m_fe_got = 8'h00;
    endtask

    task automatic model_update(input bit s, input bit v, input logic [7:0] d);
        if (s) begin
            model_reset();
            m_mode = 1;
        end else if (m_mode == 1 && v) begin
            m_beats++;
            if (d != m_x[7:0]) begin
                m_pulse = 1;
                if (m_errs < 65535) m_errs++;
                m_run++;
                if (!m_fe_valid) begin
                    m_fe_valid = 1; m_fe_idx = m_beats; m_fe_exp = m_x[7:0]; m_fe_got = d;
                end
                if (m_run == MAX_MISS) m_mode = 2;
            end else begin
                m_pulse = 0;
                m_run = 0;
            end
            m_x = model_next(m_x);
        end else begin
            m_pulse = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, ".locked"}, 32'(locked), 32'(m_mode == 1));
        chk({tag, ".lost"}, 32'(lost), 32'(m_mode == 2));
        chk({tag, ".err_pulse"}, 32'(err_pulse), 32'(m_pulse));
        chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(m_errs));
        chk({tag, ".beat_cnt"}, beat_cnt, m_beats);
`ifdef RNG_CHECKER_FIRST_ERR_EN
        chk({tag, ".fe_valid"}, 32'(first_err_valid), 32'(m_fe_valid));
        chk({tag, ".fe_idx"}, first_err_idx, m_fe_idx);
        chk({tag, ".fe_exp"}, 32'(first_err_exp), 32'(m_fe_exp));
        chk({tag, ".fe_got"}, 32'(first_err_got), 32'(m_fe_got));
`endif
    endtask

    task automatic step(input string tag, input bit s, input bit v, input logic [7:0] d);
        @(negedge clk);
        start = s; in_valid = v; in_data = d;
        @(posedge clk);
        #1;
        model_update(s, v, d);
        check_all(tag);
    endtask

    task automatic good(input string tag);
        step(tag, 1'b0, 1'b1, m_x[7:0]);
    endtask

    task automatic bad(input string tag);
        step(tag, 1'b0, 1'b1, m_x[7:0] ^ 8'($urandom_range(1, 255)));
    endtask

    initial begin
        logic [7:0] e5;
        logic [7:0] g5;
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        model_reset();
        #1;
        check_all("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Beats and gaps while idle must not be counted.
        for (int i = 0; i < 6; i++) step("idle", 1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
        chk("idle_beat_cnt", beat_cnt, 32'd0);
        chk("idle_locked", 32'(locked), 32'd0);

        // Known xorshift32 bytes from seed 1.
        step("start1", 1'b1, 1'b0, 8'h00);
        step("b1", 1'b0, 1'b1, 8'h01);
        step("b2", 1'b0, 1'b1, 8'h21);
        step("b3", 1'b0, 1'b1, 8'h01);
        chk("seq_locked", 32'(locked), 32'd1);
        chk("seq_err_cnt", 32'(err_cnt), 32'd0);
        chk("seq_beat_cnt", beat_cnt, 32'd3);

        // Single corrupted beat, then recovery; gaps in between.
        step("start2", 1'b1, 1'b0, 8'h00);
        step("c1", 1'b0, 1'b1, 8'h01);
        step("c2", 1'b0, 1'b1, 8'h20);
        chk("corrupt_pulse", 32'(err_pulse), 32'd1);
        chk("corrupt_err_cnt", 32'(err_cnt), 32'd1);
        step("gap", 1'b0, 1'b0, 8'h5a);
        step("gap", 1'b0, 1'b0, 8'ha5);
        step("c3", 1'b0, 1'b1, 8'h01);
        chk("corrupt_recover_pulse", 32'(err_pulse), 32'd0);
        chk("corrupt_recover_locked", 32'(locked), 32'd1);
        chk("corrupt_recover_beats", beat_cnt, 32'd3);
        for (int i = 0; i < 4; i++) good("c_more");

        // Start coincident with a beat: the beat is dropped.
        step("start_coinc", 1'b1, 1'b1, 8'h55);
        chk("coinc_beat_cnt", beat_cnt, 32'd0);
        step("coinc_next", 1'b0, 1'b1, 8'h01);
        chk("coinc_next_pulse", 32'(err_pulse), 32'd0);
        chk("coinc_next_beats", beat_cnt, 32'd1);

        // MAX_MISS consecutive misses declare loss of sync.
        step("start_lost", 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < MAX_MISS - 1; i++) bad("miss");
        chk("miss_still_locked", 32'(locked), 32'd1);
        bad("miss_last");
        chk("lost_flag", 32'(lost), 32'd1);
        chk("lost_err_cnt", 32'(err_cnt), 32'(MAX_MISS));
        for (int i = 0; i < 4; i++) step("lost_beat", 1'b0, 1'b1, 8'($urandom));
        chk("lost_hold_err", 32'(err_cnt), 32'(MAX_MISS));
        chk("lost_hold_beats", beat_cnt, 32'(MAX_MISS));

`ifdef RNG_CHECKER_FIRST_ERR_EN
        // Errors at beats 5 and 9: only the first is captured.
        step("start_fe", 1'b1, 1'b0, 8'h00);
        for (int i = 1; i <= 10; i++) begin
            if (i == 5) begin
                e5 = m_x[7:0];
                g5 = e5 ^ 8'h81;
                step("fe_b5", 1'b0, 1'b1, g5);
            end else if (i == 9) begin
                bad("fe_b9");
            end else begin
                good("fe_ok");
            end
        end
        chk("fe_valid_set", 32'(first_err_valid), 32'd1);
        chk("fe_idx5", first_err_idx, 32'd5);
        chk("fe_exp5", 32'(first_err_exp), 32'(e5));
        chk("fe_got5", 32'(first_err_got), 32'(g5));
        step("fe_clear", 1'b1, 1'b0, 8'h00);
        chk("fe_cleared", 32'(first_err_valid), 32'd0);
`else
        e5 = 8'h00;
        g5 = 8'h00;
`endif

        // Random stream with occasional restarts, gaps and corruption.
        for (int i = 0; i < 400; i++) begin
            logic       s;
            logic       v;
            logic [7:0] d;
            s = ($urandom_range(0, 39) == 0);
            v = ($urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 5) == 0) ? 8'($urandom) : m_x[7:0];
            step("rand", s, v, d);
        end

        // Reset during CHECK with a mismatching beat on the bus.
        step("start_rst", 1'b1, 1'b0, 8'h00);
        good("pre_rst");
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = m_x[7:0] ^ 8'hff;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0; start = 1'b0;
        @(posedge clk);
        #1;
        model_update(1'b0, 1'b0, 8'h00);
        check_all("post_rst");
        chk("post_rst_pulse", 32'(err_pulse), 32'd0);
        step("post_rst_beat", 1'b0, 1'b1, 8'h00);
        chk("post_rst_idle", 32'(beat_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
